uart_rx_frame_ctrl: RTL

//  Frame controller for the UART receiver, paired with the RX edge/bit counter.

---
 rtl/uart_rx_frame_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller: majority-samples RX_IN per bit, deserializes LSB first,
// checks start/parity/stop and reports a good frame or a single error pulse.
module uart_rx_frame_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CNT_W      = 6
) (
    input  logic                  CLK_FSM,
    input  logic                  RST_FSM,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [CNT_W-1:0]      prescale,
    input  logic [CNT_W-1:0]      bit_cnt,
    input  logic [CNT_W-1:0]      edge_cnt,
    output logic                  enable_edge,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stop_err,
    output logic                  strt_glitch
);

    localparam logic [CNT_W-1:0] LAST_DATA_BIT = CNT_W'(DATA_WIDTH);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                  state;
    logic [DATA_WIDTH-1:0]   shreg;
    logic                    s0, s1, s2, samp;
    logic                    perr;
    logic                    par_en_q, par_typ_q;
    logic                    armed;

    logic [CNT_W-1:0]        mid;
    logic                    end_of_bit;

    assign mid         = prescale >> 1;
    assign end_of_bit  = (edge_cnt == (prescale - CNT_W'(1)));
    assign enable_edge = (state != IDLE);

    // Three mid-bit samples, then their majority one edge after the last sample.
    always_ff @(posedge CLK_FSM or negedge RST_FSM) begin
        if (!RST_FSM) begin
            s0   <= 1'b0;
            s1   <= 1'b0;
            s2   <= 1'b0;
            samp <= 1'b0;
        end else begin
            if (edge_cnt == (mid - CNT_W'(1))) s0 <= RX_IN;
            if (edge_cnt == mid)               s1 <= RX_IN;
            if (edge_cnt == (mid + CNT_W'(1))) s2 <= RX_IN;
            if (edge_cnt == (mid + CNT_W'(2))) samp <= (s0 & s1) | (s0 & s2) | (s1 & s2);
        end
    end

    // Frame FSM; armed blocks a line that is already low at reset release from starting a frame.
    always_ff @(posedge CLK_FSM or negedge RST_FSM) begin
        if (!RST_FSM) begin
            state       <= IDLE;
            shreg       <= '0;
            perr        <= 1'b0;
            par_en_q    <= 1'b0;
            par_typ_q   <= 1'b0;
            armed       <= 1'b0;
            P_DATA      <= '0;
            data_valid  <= 1'b0;
            par_err     <= 1'b0;
            stop_err    <= 1'b0;
            strt_glitch <= 1'b0;
        end else begin
            data_valid  <= 1'b0;
            par_err     <= 1'b0;
            stop_err    <= 1'b0;
            strt_glitch <= 1'b0;
            armed       <= armed | RX_IN | (state != IDLE);

            case (state)
                IDLE: begin
                    if (!RX_IN && armed) begin
                        state     <= START;
                        par_en_q  <= PAR_EN;
                        par_typ_q <= PAR_TYP;
                    end
                end
                START: begin
                    if (end_of_bit) begin
                        if (samp) begin
                            state       <= IDLE;
                            strt_glitch <= 1'b1;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (end_of_bit) begin
                        shreg <= {samp, shreg[DATA_WIDTH-1:1]};
                        if (bit_cnt == LAST_DATA_BIT) state <= par_en_q ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    if (end_of_bit) begin
                        if (samp != ((^shreg) ^ par_typ_q)) perr <= 1'b1;
                        state <= STOP;
                    end
                end
                STOP: begin
                    if (end_of_bit) begin
                        if (!samp) begin
                            stop_err <= 1'b1;
                        end else if (perr) begin
                            par_err <= 1'b1;
                        end else begin
                            P_DATA     <= shreg;
                            data_valid <= 1'b1;
                        end
                        perr  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
